// File: rtl/loop_nest_ctrl_pkg.sv
// Shared definitions for the nested-loop step controller: default index
// widths and the controller state encodings.
package loop_nest_ctrl_pkg;

    // Default index / terminal-value widths.
    localparam int INNER_W_DEFAULT = 7;
    localparam int OUTER_W_DEFAULT = 7;

    // Controller state encodings. Kept as plain constants so that older
    // blocks and debug scripts that decode the raw state bits keep working.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // True when the encoding is one of the three legal states.
    function automatic logic state_is_legal(input logic [1:0] st);
        return (st == ST_IDLE) || (st == ST_RUN) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/loop_index_counter.sv
// One loop index: counts 0..last, wraps to zero after `last`, holds when
// not stepped. `clear` forces the index back to zero and wins over `step`.
module loop_index_counter
    import loop_nest_ctrl_pkg::*;
#(
    parameter int W = INNER_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear,
    input  logic         step,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         at_last
);

    logic [W-1:0] idx_q;
    logic [W-1:0] idx_d;

    // Full-width unsigned equality, so an all-ones terminal never wraps early.
    assign at_last = (idx_q == last);
    assign idx     = idx_q;

    // Next index: clear, wrap at the terminal value, increment, or hold.
    always_comb begin
        // NOTE: assigning a default before any branch keeps this block purely
        // combinational; a path that leaves idx_d unassigned would infer a latch.
        idx_d = idx_q;
        if (clear) begin
            idx_d = '0;
        end else if (step) begin
            if (at_last) begin
                idx_d = '0;
            end else begin
                idx_d = idx_q + W'(1);
            end
        end
    end

    // Index register with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values, independent of block evaluation order.
        if (!rst_n) begin
            idx_q <= '0;
        end else begin
            idx_q <= idx_d;
        end
    end

endmodule

// File: rtl/loop_nest_ctrl.sv
// Nested-loop step controller. On start it captures the inner and outer
// terminal indices and then issues (outer_idx, inner_idx) steps in
// outer-major order, one per non-stalled cycle, followed by a one-cycle
// done pulse. abort cancels a run at any time without a done pulse.
module loop_nest_ctrl
    import loop_nest_ctrl_pkg::*;
#(
    parameter int INNER_W = INNER_W_DEFAULT,
    parameter int OUTER_W = OUTER_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic               stall,
    input  logic [INNER_W-1:0] inner_last,
    input  logic [OUTER_W-1:0] outer_last,
    output logic               busy,
    output logic               step_valid,
    output logic [INNER_W-1:0] inner_idx,
    output logic [OUTER_W-1:0] outer_idx,
    output logic               row_first,
    output logic               row_last,
    output logic               done
);

    logic [1:0]         state_q;
    logic [1:0]         state_d;
    logic [INNER_W-1:0] inner_cfg_q;
    logic [INNER_W-1:0] inner_cfg_d;
    logic [OUTER_W-1:0] outer_cfg_q;
    logic [OUTER_W-1:0] outer_cfg_d;

    logic in_idle;
    logic in_run;
    logic in_done;
    logic launch;
    logic step_take;
    logic idx_clear;
    logic inner_at_last;
    logic outer_at_last;
    logic outer_step;
    logic final_step;

    // State decode.
    assign in_idle = (state_q == ST_IDLE);
    assign in_run  = (state_q == ST_RUN);
    assign in_done = (state_q == ST_DONE);

    // A run is launched only from IDLE, and abort always wins over start.
    assign launch = in_idle & start & ~abort;

    // A step is issued whenever RUN is not stalled; it only advances the
    // indices when no abort cancels the run in the same cycle.
    assign step_take  = in_run & ~stall & ~abort;
    assign outer_step = step_take & inner_at_last;
    assign final_step = outer_step & outer_at_last;

    // Outside RUN the indices are held at zero; abort zeroes them as well.
    assign idx_clear = abort | ~in_run;

    loop_index_counter #(
        .W (INNER_W)
    ) u_inner_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (idx_clear),
        .step    (step_take),
        .last    (inner_cfg_q),
        .idx     (inner_idx),
        .at_last (inner_at_last)
    );

    loop_index_counter #(
        .W (OUTER_W)
    ) u_outer_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (idx_clear),
        .step    (outer_step),
        .last    (outer_cfg_q),
        .idx     (outer_idx),
        .at_last (outer_at_last)
    );

    // Next-state logic; abort returns to IDLE from any state.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (launch)     state_d = ST_RUN;
            ST_RUN:  if (final_step) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
        if (abort || !state_is_legal(state_q)) begin
            state_d = ST_IDLE;
        end
    end

    // Terminal values are captured only at launch and ignored afterwards.
    always_comb begin
        inner_cfg_d = inner_cfg_q;
        outer_cfg_d = outer_cfg_q;
        if (launch) begin
            inner_cfg_d = inner_last;
            outer_cfg_d = outer_last;
        end
    end

    // State and configuration registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            inner_cfg_q <= '0;
            outer_cfg_q <= '0;
        end else begin
            state_q     <= state_d;
            inner_cfg_q <= inner_cfg_d;
            outer_cfg_q <= outer_cfg_d;
        end
    end

    // Status outputs come from the state decode; the step qualifiers follow
    // stall combinationally so the datapath sees them in the same cycle.
    assign busy       = in_run;
    assign done       = in_done;
    assign step_valid = in_run & ~stall;
    assign row_first  = step_valid & (inner_idx == '0);
    assign row_last   = step_valid & inner_at_last;

endmodule
